// File: rtl/dac_serializer_pkg.sv
// Shared defaults and helpers for the WM8731 DAC serializer.
package dac_serializer_pkg;
  localparam int DEF_MCLK_HALF   = 2;
  localparam int DEF_BCLK_HALF   = 8;
  localparam int DEF_FRAME_BCLKS = 64;
  localparam int DEF_SAMPLE_W    = 32;
  localparam int SLOT_W          = $clog2(DEF_FRAME_BCLKS);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dac_serializer_clk_div.sv
// Toggle divider: clk_out flips every HALF clks while run is high, else held low.
module clk_div_toggle
  import dac_serializer_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic clk_out,
  output logic rise_pulse
);
  localparam int CW = cnt_width(HALF);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(HALF - 1));
  // High in the cycle whose closing edge drives clk_out 0->1.
  assign rise_pulse = run && wrap && !clk_out;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dac_serializer.sv
// WM8731 DAC transmitter: generates m_clk/b_clk/dac_lr_clk and shifts one
// stereo sample per frame out MSB-first on dacdat.
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int MCLK_HALF   = DEF_MCLK_HALF,
  parameter int BCLK_HALF   = DEF_BCLK_HALF,
  parameter int FRAME_BCLKS = DEF_FRAME_BCLKS,
  parameter int SAMPLE_W    = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                underrun,
  output logic                m_clk,
  output logic                b_clk,
  output logic                dac_lr_clk,
  output logic                dacdat
);
  localparam int SW = cnt_width(FRAME_BCLKS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_BCLKS - 1);
  localparam logic [SW-1:0] HALF_SLOT = SW'(FRAME_BCLKS / 2);

  logic b_rise, mclk_rise_unused;

  clk_div_toggle #(.HALF(MCLK_HALF)) u_mclk (
    .clk(clk), .reset(reset), .run(1'b1),
    .clk_out(m_clk), .rise_pulse(mclk_rise_unused)
  );

  clk_div_toggle #(.HALF(BCLK_HALF)) u_bclk (
    .clk(clk), .reset(reset), .run(enable),
    .clk_out(b_clk), .rise_pulse(b_rise)
  );

  // slot holds the slot number that the next b_clk rise enters.
  logic [SW-1:0]       slot;
  logic [SAMPLE_W-1:0] hold, shreg, last, load_val;
  logic                pending, pending_n;
  logic                frame_start, accept, bypass;

  always_comb begin
    frame_start = b_rise && (slot == '0);
    accept      = sample_valid && sample_ready;
    bypass      = frame_start && !pending && sample_valid;
    load_val    = last;
    if (pending)           load_val = hold;
    else if (sample_valid) load_val = sample_data;
    pending_n = pending;
    if (frame_start && pending) pending_n = 1'b0;
    else if (accept && !bypass) pending_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot         <= '0;
      hold         <= '0;
      shreg        <= '0;
      last         <= '0;
      pending      <= 1'b0;
      sample_ready <= 1'b1;
      underrun     <= 1'b0;
      dac_lr_clk   <= 1'b0;
      dacdat       <= 1'b0;
    end else begin
      underrun     <= 1'b0;
      pending      <= pending_n;
      sample_ready <= !pending_n;
      if (accept && !bypass) hold <= sample_data;

      if (!enable) begin
        slot       <= '0;
        dac_lr_clk <= 1'b0;
        dacdat     <= 1'b0;
      end else if (b_rise) begin
        slot       <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        dac_lr_clk <= (slot < HALF_SLOT);
        if (frame_start) begin
          shreg    <= {load_val[SAMPLE_W-2:0], 1'b0};
          dacdat   <= load_val[SAMPLE_W-1];
          last     <= load_val;
          underrun <= !pending && !sample_valid;
        end else begin
          // Zeros shift in, so slots past the sample width carry 0.
          shreg  <= {shreg[SAMPLE_W-2:0], 1'b0};
          dacdat <= shreg[SAMPLE_W-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_dac_serializer.sv
// Directed + random bench for dac_serializer with a frame-level reference model
// and a receiver-side monitor sampling on b_clk falling edges.
module tb_dac_serializer;
  localparam int MH = 2, BH = 8, FR = 64, W = 32;
  localparam int FP = 2 * BH * FR;

  logic         clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0;
  logic [W-1:0] sample_data = '0;
  logic         sample_ready, underrun, m_clk, b_clk, dac_lr_clk, dacdat;

  dac_serializer #(.MCLK_HALF(MH), .BCLK_HALF(BH), .FRAME_BCLKS(FR), .SAMPLE_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .underrun(underrun),
    .m_clk(m_clk), .b_clk(b_clk), .dac_lr_clk(dac_lr_clk), .dacdat(dacdat)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame starts fall on every FR-th b_clk rise; rises happen BH-1 enabled
  // edges after enable and then every 2*BH edges.
  function automatic bit is_fs(input int c);
    return (c >= BH - 1) && (((c - (BH - 1)) % FP) == 0);
  endfunction

  // Reference model of the handshake and per-frame sample choice.
  int           m_encnt = 0;
  logic         m_pend = 1'b0, m_under = 1'b0;
  logic [W-1:0] m_hold = '0, m_last = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin : model
    logic         fs, take;
    logic [W-1:0] v;
    if (reset) begin
      m_encnt <= 0; m_pend <= 1'b0; m_under <= 1'b0; m_hold <= '0; m_last <= '0;
      exp_q.delete();
    end else begin
      fs      = enable && is_fs(m_encnt);
      take    = sample_valid && !m_pend;
      m_encnt <= enable ? m_encnt + 1 : 0;
      m_under <= 1'b0;
      if (!enable) exp_q.delete();
      if (fs) begin
        if (m_pend)            v = m_hold;
        else if (sample_valid) v = sample_data;
        else                   v = m_last;
        exp_q.push_back(v);
        m_last  <= v;
        m_under <= !m_pend && !sample_valid;
      end
      if (fs && m_pend)      m_pend <= 1'b0;
      else if (take && !fs) begin
        m_pend <= 1'b1;
        m_hold <= sample_data;
      end
    end
  end

  // Receiver / timing monitor, sampled on clk negedge.
  logic         pb = 1'b0, plr = 1'b0, pm = 1'b0;
  int           mgap = 0, bgap = 0, lgap = 0, k = 0, tail = 0, lrh = 0, frames = 0, uw = 0;
  bit           mval = 0, bval = 0, lval = 0, cap = 0;
  logic [W-1:0] cw = '0, expw = '0;
  logic [W-1:0] got_q[$];

  always @(negedge clk) begin
    chk("ready", 64'(sample_ready), 64'(!m_pend));
    chk("underrun", 64'(underrun), 64'(m_under));
    if (reset) uw = 0;
    else if (underrun === 1'b1) uw++;
    else begin
      if (uw > 0) chk("underrun_width", 64'(uw), 64'(1));
      uw = 0;
    end

    mgap++;
    if (reset) begin
      mval = 0; mgap = 0;
      chk("mclk_rst", 64'(m_clk), 64'(0));
    end else if (m_clk !== pm) begin
      if (mval) chk("mclk_half", 64'(mgap), 64'(MH));
      mval = 1; mgap = 0;
    end
    pm = m_clk;

    if (reset || !enable) begin
      chk("bclk_idle", 64'(b_clk), 64'(0));
      chk("lr_idle", 64'(dac_lr_clk), 64'(0));
      chk("dat_idle", 64'(dacdat), 64'(0));
      cap = 0; bval = 0; lval = 0; bgap = 0; lgap = 0; plr = 1'b0;
    end else begin
      bgap++; lgap++;
      if (pb && !b_clk) begin
        if (bval) chk("bclk_period", 64'(bgap), 64'(2 * BH));
        bval = 1; bgap = 0;
        if (dac_lr_clk && !plr) begin
          if (lval) chk("lr_period", 64'(lgap), 64'(FP));
          lval = 1; lgap = 0;
          chk("exp_avail", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            expw = exp_q.pop_front();
            cap = 1; k = 0; tail = 0; lrh = 0; cw = '0;
          end
        end
        if (cap) begin
          if (k < W) cw = {cw[W-2:0], dacdat};
          else       tail += int'(dacdat);
          lrh += int'(dac_lr_clk);
          k++;
          if (k == W) begin
            chk("frame_data", 64'(cw), 64'(expw));
            got_q.push_back(cw);
          end
          if (k == FR) begin
            chk("tail_zero", 64'(tail), 64'(0));
            chk("lr_high", 64'(lrh), 64'(FR / 2));
            cap = 0;
            frames++;
          end
        end
        plr = dac_lr_clk;
      end
    end
    pb = b_clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    int c = 0;
    bit r = 0;
    sample_valid = 1'b1;
    sample_data  = d;
    do begin
      r = sample_ready;
      tick(1);
      c++;
    end while (!r && c < 3 * FP);
    chk("push_timeout", 64'(r), 64'(1));
  endtask

  task automatic wait_frames(input int n);
    int target = frames + n;
    int c = 0;
    while (frames < target && c < (n + 2) * FP) begin
      tick(1);
      c++;
    end
    chk("frame_timeout", 64'(frames >= target), 64'(1));
  endtask

  task automatic wait_fs();
    int c = 0;
    while (!is_fs(m_encnt) && c < 2 * FP) begin
      tick(1);
      c++;
    end
    chk("fs_timeout", 64'(is_fs(m_encnt)), 64'(1));
  endtask

  initial begin
    int i;
    tick(3);
    chk("rst_ready", 64'(sample_ready), 64'(1));
    chk("rst_under", 64'(underrun), 64'(0));
    chk("rst_lr", 64'(dac_lr_clk), 64'(0));
    chk("rst_dat", 64'(dacdat), 64'(0));
    chk("rst_bclk", 64'(b_clk), 64'(0));
    chk("rst_mclk", 64'(m_clk), 64'(0));

    // First frame carries a sample loaded before it starts.
    reset = 1'b0; enable = 1'b1;
    push(32'hA5A51234);
    sample_valid = 1'b0;
    wait_frames(1);
    chk("first_frame", 64'(got_q[got_q.size()-1]), 64'(32'hA5A51234));
    wait_frames(1);

    // Back-to-back stream with valid held high.
    got_q.delete();
    push(32'h0000_0001);
    push(32'h8000_0000);
    push(32'hFFFF_0000);
    sample_valid = 1'b0;
    wait_frames(3);
    i = -1;
    foreach (got_q[j]) if (i < 0 && got_q[j] == 32'h1) i = j;
    chk("b2b_found", 64'(i >= 0 && i + 2 < got_q.size()), 64'(1));
    if (i >= 0 && i + 2 < got_q.size()) begin
      chk("b2b_second", 64'(got_q[i+1]), 64'(32'h8000_0000));
      chk("b2b_third", 64'(got_q[i+2]), 64'(32'hFFFF_0000));
    end

    // Starved stream repeats the previous sample.
    push(32'h1234_5678);
    sample_valid = 1'b0;
    wait_frames(3);
    chk("repeat_a", 64'(got_q[got_q.size()-2]), 64'(32'h1234_5678));
    chk("repeat_b", 64'(got_q[got_q.size()-1]), 64'(32'h1234_5678));

    // Bypass: valid only in the frame-start cycle with nothing pending.
    wait_fs();
    sample_valid = 1'b1; sample_data = 32'hDEAD_BEEF;
    tick(1);
    sample_valid = 1'b0;
    chk("bypass_ready", 64'(sample_ready), 64'(1));
    chk("bypass_no_underrun", 64'(underrun), 64'(0));
    wait_frames(1);
    chk("bypass_frame", 64'(got_q[got_q.size()-1]), 64'(32'hDEAD_BEEF));

    // Random samples with random gaps.
    repeat (6) begin
      push($urandom);
      sample_valid = 1'b0;
      tick($urandom_range(0, 1500));
    end
    wait_frames(2);

    // Reset at slot 10, then a fresh run.
    wait_fs();
    tick(10 * 2 * BH + 3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    push(32'h0F0F_0F0F);
    sample_valid = 1'b0;
    wait_fs();
    tick(300);

    // Pending sample must survive an enable drop mid-frame.
    push(32'hCAFE_F00D);
    sample_valid = 1'b0;
    enable = 1'b0;
    tick(1);
    chk("pend_kept", 64'(sample_ready), 64'(0));
    tick(50);
    enable = 1'b1;
    got_q.delete();
    wait_frames(1);
    chk("resume_frame", 64'(got_q.size() > 0 ? got_q[0] : '0), 64'(32'hCAFE_F00D));

    enable = 1'b0;
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
RTL transmitter for the WM8731 DAC audio path. It accepts 32-bit stereo samples over a valid/ready handshake and generates m_clk, b_clk and dac_lr_clk from the system clock. Each sample is shifted out MSB-first on dacdat, one sample per frame. It drives the codec's DAC pins directly, and the existing DAC bench monitor checks its output.

Parameters:
MCLK_HALF, 2, m_clk half-period in clk cycles (>=1; 50 MHz clk -> 12.5 MHz m_clk)
BCLK_HALF, 8, b_clk half-period in clk cycles (>=2)
FRAME_BCLKS, 64, b_clk periods per dac_lr_clk frame (even, >=SAMPLE_W)
SAMPLE_W, 32, bits per frame ([31:16] left, [15:0] right)

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run serial clocks/frames; 0 = idle
sample_data  input  SAMPLE_W  sample to transmit
sample_valid  input  1  sample_data valid
sample_ready  output  1  holding register empty; transfer when valid && ready
underrun  output  1  one-clk pulse: frame started with no new sample
m_clk  output  1  codec master clock, free-running
b_clk  output  1  bit clock
dac_lr_clk  output  1  frame clock, high for first FRAME_BCLKS/2 slots
dacdat  output  1  serial data

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high.
  - All outputs are registered. Reset values: m_clk=0, b_clk=0, dac_lr_clk=0, dacdat=0, sample_ready=1, underrun=0.
  - Reset also clears all counters, the holding register, the pending flag and the shift register.
- m_clk:
  - Toggles every MCLK_HALF clks.
  - Runs whenever reset=0, regardless of enable.
- b_clk:
  - Divider counter runs 0..BCLK_HALF-1; b_clk toggles on wrap.
  - While enable=0: b_clk, dac_lr_clk and dacdat are held 0, and the divider and slot counters are held at 0.
  - The first b_clk rise occurs BCLK_HALF clks after enable is sampled high.
- Slot counter:
  - Counts 0..FRAME_BCLKS-1, advancing on each b_clk rising edge.
  - dac_lr_clk and dacdat change only in the same clk cycle that b_clk goes 0->1.
  - They are therefore stable across every b_clk falling edge, where the codec samples.
- Slot 0 (frame start):
  - dac_lr_clk goes 1, and the shift register loads the next sample.
  - dacdat = sample bit SAMPLE_W-1 in slot 0, then bit SAMPLE_W-1-k in slot k.
  - Slots >= SAMPLE_W: dacdat=0.
  - Slot FRAME_BCLKS/2: dac_lr_clk goes 0.
  - Receiver view: the first b_clk negedge after dac_lr_clk posedge captures the MSB; 32 consecutive negedges capture the full sample.
- Handshake and sample selection:
  - sample_ready = !pending.
  - When valid && ready: the holding register takes sample_data and pending is set.
  - At a frame-start load:
    - If pending: load the holding register and clear pending.
    - Else, if sample_valid is high in that same cycle: bypass, loading sample_data directly. No underrun; handshake completes and pending stays 0.
    - Else: reload the previous sample (zero after reset) and pulse underrun for 1 clk.
  - Holding-register write and frame-start load in the same cycle with pending=1: the load takes the old contents; the new write is refused because ready=0.
- Enable deasserted mid-frame:
  - Serial outputs go to 0 on the next clk and counters reset.
  - The holding register and pending flag are kept.
  - The next enable starts a fresh frame at slot 0.
- Reset mid-frame: everything returns to reset values on the next clk; no partial frame resumes.
- Frequencies with defaults: m_clk=clk/4, b_clk=clk/16, dac_lr_clk=clk/1024.

Decomposition:
- Package dac_serializer_pkg holds:
  - default divider/frame constants;
  - SAMPLE_W;
  - slot counter width, $clog2(FRAME_BCLKS).
- One sub-module, clk_div_toggle: parameter HALF, inputs clk/reset/run, outputs clk_out plus a rise_pulse strobe. Instantiated twice: m_clk with run=1, b_clk with run=enable.
- The slot counter, shifter and handshake live in the top module.

Test Plan:
- Reset, enable=1, load 0xA5A51234 before the first frame -> monitor captures 0xA5A51234 on b_clk negedges after dac_lr_clk posedge; dacdat=0 in slots 32..63.
- Frequency check with clk=50 MHz -> m_clk 12.5 MHz, b_clk 3.125 MHz, dac_lr_clk 48.828 kHz; dac_lr_clk high for exactly 32 b_clk periods.
- Back-to-back stream 0x00000001, 0x80000000, 0xFFFF0000, with valid held high -> three consecutive frames carry them in order; no underrun; sample_ready low for one frame between accepts.
- No sample supplied after 0x12345678 -> next frame repeats 0x12345678; underrun pulses exactly 1 clk at that frame start.
- sample_valid asserted with pending=0 exactly in the frame-start cycle, data 0xDEADBEEF -> that frame carries 0xDEADBEEF; underrun stays 0.
- Reset asserted at slot 10, then enable=0 mid-frame on a second run -> outputs go to 0 the next clk; the next frame starts cleanly with MSB in slot 0, and the pending sample survives the enable toggle.
